mul_operand_packer: RTL and testbench
=====================================

// Module: mul_operand_packer
// PURPOSE
//  Input-side packer for the 7-multiplier product-node tree (mul_tree). Takes a serial stream of float32 operands,
//  groups them into products of fan-in N = 2/3/4/6 and packs P products per bundle into the tree's 256-bit mul_ins word.
//  Drives mode and a one-cycle mul_stb. Unused or short slots are padded with float 1.0.
// PARAMETERS
//  ONE_VAL    32'h3F800000  pad value (IEEE-754 single 1.0)
//  STAT_W     16            width of statistics counters (MUL_PACK_STATS_EN only)
// PORTS
//  clk          in   1    clock, all flops rising edge
//  rst          in   1    asynchronous, active-low reset
//  op_data      in   32   float32 operand
//  op_mode      in   2    00 two_in, 01 three_in, 10 four_in, 11 six_in; sampled on first operand of a bundle
//  op_last      in   1    marks final operand of the current product
//  op_valid     in   1    operand valid
//  op_ready     out  1    operand accepted when op_valid & op_ready
//  flush        in   1    issue a partially filled bundle
//  mul_ins      out  256  packed operands; slot k = bits[32k+31:32k]; pairs {slot 2m+1, slot 2m} feed multiplier m
//  mode         out  2    mode of the issued bundle
//  mul_stb      out  1    one-cycle pulse, mul_ins/mode valid
//  prod_mask    out  4    real products in the issued bundle; bit j = tree output j
//  fanin_err    out  1    one-cycle pulse, product closed at N operands without op_last
// BEHAVIOUR
//  - Per mode: N = 2/3/4/6, P = 4/2/2/1.
//  - Slot order per product:
//      two_in:   p0 {0,1}, p1 {2,3}, p2 {4,5}, p3 {6,7}
//      three_in: p0 {0,1,2}, p1 {4,5,6}
//      four_in:  p0 {0..3}, p1 {4..7}
//      six_in:   p0 {0..5}
//  - Slots not used by the mode (three_in 3,7; six_in 6,7) are driven ONE_VAL.
//  - States:
//      IDLE  empty, op_ready=1; first accepted operand latches op_mode -> FILL
//      FILL  op_ready=1; op_mode changes are ignored until the bundle is issued
//      ISSUE one cycle, op_ready=0; mul_stb=1 -> IDLE
//  - Operand counter opc (0..N-1) and product counter pc (0..P-1).
//      Accepted operand is written to the slot for (pc, opc).
//  - Product closes on op_last, or when opc reaches N-1.
//      Closing at N-1 without op_last: fanin_err pulses in the next cycle.
//      op_last before N operands: the remaining slots of that product hold ONE_VAL (identity).
//  - Bundle closes when product P-1 closes, or on flush while in FILL.
//      Unfilled products: all slots ONE_VAL, mask bit 0.
//  - Latency: the closing operand is accepted in cycle t -> mul_stb=1 in cycle t+1.
//      mul_ins, mode and prod_mask are registered and held until the next issue.
//  - Assembly buffer is preset to all ONE_VAL when entering IDLE.
//  - Boundary cases:
//      flush in IDLE: ignored, no pulse.
//      flush with an accepted operand in the same cycle: operand included first, then one issue.
//      flush with op_last completing the bundle: exactly one issue.
//      flush during ISSUE: ignored.
//      op_last with opc at N-1: normal close, no error.
//  - Reset (any time, including mid-bundle):
//      partial bundle discarded; state IDLE.
//      mul_ins = {8{ONE_VAL}}, mode = 0, mul_stb = 0, prod_mask = 0, fanin_err = 0, op_ready = 1.
// CONFIGURATION
//  MUL_PACK_STATS_EN defined:
//      adds outputs stat_bundles [STAT_W] (+1 per mul_stb) and stat_pads [STAT_W] (+1 per ONE_VAL slot issued
//      within real products only).
//      Both counters saturate at all-ones and reset to 0.
//  MUL_PACK_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. two_in, operands 2.0,3.0 | 0.5,2.0 | 1.0,1.0 | 3.0,3.0, op_last on every 2nd operand
//       -> one mul_stb 1 cycle after the 8th operand; mode=00; prod_mask=1111;
//          mul_ins = {40400000,40400000,3F800000,3F800000,40000000,3F000000,40400000,40000000}
//          (slot7 first, slot0 last).
//  2. three_in, 6 operands 40000000 each, op_last on the 3rd and 6th
//       -> slots 0,1,2,4,5,6 = 40000000; slots 3,7 = 3F800000; mode=01; prod_mask=0011.
//  3. six_in, 4 operands with op_last on the 4th
//       -> slots 4..7 = 3F800000; mask=0001; fanin_err never pulses.
//     Then 6 operands without op_last -> issue with fanin_err=1 for one cycle.
//  4. four_in, 4 operands, then flush
//       -> mask=0011? no: mask=0001, slots 4..7 = ONE_VAL.
//     flush in IDLE -> no mul_stb; op_ready=0 only in the ISSUE cycle.
//  5. Reset asserted after 3 operands of a two_in bundle
//       -> outputs return to their reset values; next 8 operands produce a clean bundle with no stale data.
//     op_mode toggled mid-bundle has no effect on mode.
//  6. With MUL_PACK_STATS_EN: after tests 1-3, stat_bundles = 4 and stat_pads = 2 (test 3 short product);
//     saturation is checked with STAT_W = 2.

Source files
------------

// File: rtl/mul_operand_packer.sv
// Packs a serial float32 operand stream into 256-bit product bundles for mul_tree; 1-cycle issue latency.
// op_ready drops only in the ISSUE cycle. Optional statistics counters are enabled with MUL_PACK_STATS_EN.
module mul_operand_packer #(
  parameter logic [31:0] ONE_VAL = 32'h3F800000,
  parameter int          STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       op_data,
  input  logic [1:0]        op_mode,
  input  logic              op_last,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              flush,
  output logic [255:0]      mul_ins,
  output logic [1:0]        mode,
  output logic              mul_stb,
  output logic [3:0]        prod_mask,
  output logic              fanin_err
`ifdef MUL_PACK_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_bundles,
  output logic [STAT_W-1:0] stat_pads
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [7:0][31:0] asm_q, asm_d;
  logic [1:0]       mode_q;
  logic [2:0]       opc_q;
  logic [1:0]       pc_q;
  logic [3:0]       mask_q, mask_d;
  logic [255:0]     ins_q;
  logic [1:0]       mode_o_q;
  logic [3:0]       pmask_q;
  logic             err_q;

  logic       accept;
  logic [1:0] cur_mode;
  logic [2:0] n_last;
  logic [1:0] p_last;
  logic [2:0] slot_base;
  logic [2:0] slot;
  logic       at_n;
  logic       prod_close;
  logic       bundle_close;

  // Operand routing uses the latched mode, except for the very first operand of a bundle.
  always_comb begin
    accept   = op_valid && op_ready;
    cur_mode = (state_q == IDLE) ? op_mode : mode_q;
    n_last    = 3'd1;
    p_last    = 2'd3;
    slot_base = {pc_q, 1'b0};
    case (cur_mode)
      2'b00: begin n_last = 3'd1; p_last = 2'd3; slot_base = {pc_q, 1'b0};       end
      2'b01: begin n_last = 3'd2; p_last = 2'd1; slot_base = {pc_q[0], 2'b00};   end
      2'b10: begin n_last = 3'd3; p_last = 2'd1; slot_base = {pc_q[0], 2'b00};   end
      default: begin n_last = 3'd5; p_last = 2'd0; slot_base = 3'd0;            end
    endcase
    slot         = slot_base + opc_q;
    at_n         = (opc_q == n_last);
    prod_close   = accept && (op_last || at_n);
    bundle_close = (prod_close && (pc_q == p_last)) ||
                   (flush && ((state_q == FILL) || accept));
    asm_d  = asm_q;
    mask_d = mask_q;
    if (accept) begin
      asm_d[slot]  = op_data;
      mask_d[pc_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b1;
    case (state_q)
      IDLE:  if (accept) state_d = bundle_close ? ISSUE : FILL;
      FILL:  if (bundle_close) state_d = ISSUE;
      ISSUE: begin
        op_ready = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The assembly buffer is re-preset to ONE_VAL on the issuing edge, so it is clean in ISSUE and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q    <= {8{ONE_VAL}};
      mode_q   <= 2'd0;
      opc_q    <= 3'd0;
      pc_q     <= 2'd0;
      mask_q   <= 4'd0;
      ins_q    <= {8{ONE_VAL}};
      mode_o_q <= 2'd0;
      pmask_q  <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && at_n && !op_last;
      if (state_q != ISSUE && bundle_close) begin
        ins_q    <= asm_d;
        mode_o_q <= cur_mode;
        pmask_q  <= mask_d;
        asm_q    <= {8{ONE_VAL}};
        opc_q    <= 3'd0;
        pc_q     <= 2'd0;
        mask_q   <= 4'd0;
      end else if (accept) begin
        asm_q  <= asm_d;
        mask_q <= mask_d;
        if (state_q == IDLE) mode_q <= op_mode;
        if (prod_close) begin
          opc_q <= 3'd0;
          pc_q  <= pc_q + 2'd1;
        end else begin
          opc_q <= opc_q + 3'd1;
        end
      end
    end
  end

  assign mul_ins   = ins_q;
  assign mode      = mode_o_q;
  assign prod_mask = pmask_q;
  assign fanin_err = err_q;
  assign mul_stb   = (state_q == ISSUE);

`ifdef MUL_PACK_STATS_EN
  logic [7:0]        wr_q, wr_d;
  logic [7:0]        prod_slots;
  logic [3:0]        pads_now;
  logic [STAT_W+3:0] pads_sum;
  logic [STAT_W:0]   bnd_sum;

  // Pads are slots inside real products that never received an operand.
  always_comb begin
    wr_d = wr_q;
    if (accept) wr_d[slot] = 1'b1;
    prod_slots = 8'd0;
    case (cur_mode)
      2'b00: begin
        for (int j = 0; j < 4; j++)
          if (mask_d[j]) prod_slots[2*j +: 2] = 2'b11;
      end
      2'b01: begin
        if (mask_d[0]) prod_slots[2:0] = 3'b111;
        if (mask_d[1]) prod_slots[6:4] = 3'b111;
      end
      2'b10: begin
        if (mask_d[0]) prod_slots[3:0] = 4'hF;
        if (mask_d[1]) prod_slots[7:4] = 4'hF;
      end
      default: if (mask_d[0]) prod_slots[5:0] = 6'h3F;
    endcase
    pads_now = 4'd0;
    for (int k = 0; k < 8; k++)
      pads_now = pads_now + {3'd0, prod_slots[k] & ~wr_d[k]};
    pads_sum = {4'd0, stat_pads} + {{STAT_W{1'b0}}, pads_now};
    bnd_sum  = {1'b0, stat_bundles} + {{STAT_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q         <= 8'd0;
      stat_bundles <= '0;
      stat_pads    <= '0;
    end else if (state_q != ISSUE && bundle_close) begin
      wr_q         <= 8'd0;
      stat_bundles <= bnd_sum[STAT_W] ? {STAT_W{1'b1}} : bnd_sum[STAT_W-1:0];
      stat_pads    <= (pads_sum[STAT_W+3:STAT_W] != 4'd0) ? {STAT_W{1'b1}} : pads_sum[STAT_W-1:0];
    end else if (accept) begin
      wr_q <= wr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mul_operand_packer.sv
// Directed self-checking bench for mul_operand_packer.
module tb_mul_operand_packer;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  op_data;
  logic [1:0]   op_mode;
  logic         op_last;
  logic         op_valid;
  logic         op_ready;
  logic         flush;
  logic [255:0] mul_ins;
  logic [1:0]   mode;
  logic         mul_stb;
  logic [3:0]   prod_mask;
  logic         fanin_err;

  int errors = 0;
  int checks = 0;

`ifdef MUL_PACK_STATS_EN
  logic [15:0] stat_bundles, stat_pads;
  logic [1:0]  sb2, sp2;
  logic        rdy2, stb2, err2;
  logic [255:0] ins2;
  logic [1:0]  mode2;
  logic [3:0]  mask2;
  mul_operand_packer #(.STAT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .op_data(op_data), .op_mode(op_mode), .op_last(op_last),
    .op_valid(op_valid), .op_ready(rdy2), .flush(flush), .mul_ins(ins2), .mode(mode2),
    .mul_stb(stb2), .prod_mask(mask2), .fanin_err(err2),
    .stat_bundles(sb2), .stat_pads(sp2));
`endif

  mul_operand_packer dut (
    .clk(clk), .rst(rst), .op_data(op_data), .op_mode(op_mode), .op_last(op_last),
    .op_valid(op_valid), .op_ready(op_ready), .flush(flush), .mul_ins(mul_ins),
    .mode(mode), .mul_stb(mul_stb), .prod_mask(prod_mask), .fanin_err(fanin_err)
`ifdef MUL_PACK_STATS_EN
    , .stat_bundles(stat_bundles), .stat_pads(stat_pads)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand; returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic l, input logic f);
    int cnt;
    @(negedge clk);
    op_data = d; op_mode = m; op_last = l; op_valid = 1'b1; flush = f;
    cnt = 0;
    while (!op_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) check("ready_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_last = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; op_data = '0; op_mode = 2'b00; op_last = 1'b0; op_valid = 1'b0; flush = 1'b0;
    #12;
    check("rst_ins",   mul_ins,   {8{ONE}});
    check("rst_mode",  mode,      0);
    check("rst_stb",   mul_stb,   0);
    check("rst_mask",  prod_mask, 0);
    check("rst_err",   fanin_err, 0);
    check("rst_ready", op_ready,  1);
    @(negedge clk); rst = 1'b1;

    // two_in, four full products
    send(32'h40000000, 2'b00, 0, 0); send(32'h40400000, 2'b00, 1, 0);
    send(32'h3F000000, 2'b00, 0, 0); send(32'h40000000, 2'b00, 1, 0);
    send(32'h3F800000, 2'b00, 0, 0); send(32'h3F800000, 2'b00, 1, 0);
    send(32'h40400000, 2'b00, 0, 0);
    check("t1_stb_early", mul_stb, 0);
    send(32'h40400000, 2'b00, 1, 0);
    check("t1_stb",   mul_stb, 1);
    check("t1_ready", op_ready, 0);
    check("t1_mode",  mode, 2'b00);
    check("t1_mask",  prod_mask, 4'hF);
    check("t1_err",   fanin_err, 0);
    check("t1_ins",   mul_ins, {32'h40400000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                                32'h40000000, 32'h3F000000, 32'h40400000, 32'h40000000});
    idle(1);
    check("t1_stb_once", mul_stb, 0);
    check("t1_ready_back", op_ready, 1);

    // three_in, unused slots 3 and 7 stay ONE
    send(32'h40000000, 2'b01, 0, 0); send(32'h40000000, 2'b01, 0, 0);
    send(32'h40000000, 2'b01, 1, 0);
    check("t2_err_exact", fanin_err, 0);
    send(32'h40000000, 2'b01, 0, 0); send(32'h40000000, 2'b01, 0, 0);
    send(32'h40000000, 2'b01, 1, 0);
    check("t2_stb",  mul_stb, 1);
    check("t2_mode", mode, 2'b01);
    check("t2_mask", prod_mask, 4'h3);
    check("t2_ins",  mul_ins, {ONE, 32'h40000000, 32'h40000000, 32'h40000000,
                               ONE, 32'h40000000, 32'h40000000, 32'h40000000});

    // six_in short product, then full product without op_last
    send(32'h40800000, 2'b11, 0, 0); send(32'h40A00000, 2'b11, 0, 0);
    send(32'h40C00000, 2'b11, 0, 0); send(32'h40E00000, 2'b11, 1, 0);
    check("t3a_stb",  mul_stb, 1);
    check("t3a_err",  fanin_err, 0);
    check("t3a_mask", prod_mask, 4'h1);
    check("t3a_ins",  mul_ins, {ONE, ONE, ONE, ONE,
                                32'h40E00000, 32'h40C00000, 32'h40A00000, 32'h40800000});
    for (int i = 0; i < 5; i++) send(32'h41000000, 2'b11, 0, 0);
    check("t3b_stb_early", mul_stb, 0);
    send(32'h41100000, 2'b11, 0, 0);
    check("t3b_stb",  mul_stb, 1);
    check("t3b_err",  fanin_err, 1);
    check("t3b_mode", mode, 2'b11);
    check("t3b_ins",  mul_ins, {ONE, ONE, 32'h41100000, {5{32'h41000000}}});
    idle(1);
    check("t3b_err_pulse", fanin_err, 0);
`ifdef MUL_PACK_STATS_EN
    check("st_bundles", stat_bundles, 4);
    check("st_pads",    stat_pads, 2);
    check("st_bundles_sat", sb2, 3);
    check("st_pads_w2",     sp2, 2);
`endif

    // four_in, one full product then flush
    send(32'h3E800000, 2'b10, 0, 0); send(32'h3E800000, 2'b10, 0, 0);
    send(32'h3E800000, 2'b10, 0, 0); send(32'h3E800000, 2'b10, 0, 0);
    check("t4_err",  fanin_err, 1);
    check("t4_stb_early", mul_stb, 0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("t4_stb",   mul_stb, 1);
    check("t4_ready", op_ready, 0);
    check("t4_mask",  prod_mask, 4'h1);
    check("t4_mode",  mode, 2'b10);
    check("t4_ins",   mul_ins, {ONE, ONE, ONE, ONE, {4{32'h3E800000}}});
    idle(1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("t4_idle_flush", mul_stb, 0);
    idle(1);
    check("t4_idle_flush2", mul_stb, 0);

    // flush together with an operand: included, one issue
    send(32'h40200000, 2'b10, 0, 1);
    check("t4f_stb",  mul_stb, 1);
    check("t4f_mask", prod_mask, 4'h1);
    check("t4f_ins",  mul_ins, {{7{ONE}}, 32'h40200000});
    idle(1);
    check("t4f_once", mul_stb, 0);
`ifdef MUL_PACK_STATS_EN
    check("st_pads_sat", sp2, 3);
`endif

    // reset mid-bundle, then clean bundle with op_mode toggling
    send(32'h11111111, 2'b00, 0, 0); send(32'h22222222, 2'b00, 1, 0);
    send(32'h33333333, 2'b00, 0, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("t5_rst_ins",  mul_ins, {8{ONE}});
    check("t5_rst_mask", prod_mask, 0);
    check("t5_rst_rdy",  op_ready, 1);
    @(negedge clk); rst = 1'b1;
    send(32'h40000001, 2'b00, 0, 0); send(32'h40000002, 2'b11, 1, 0);
    send(32'h40000003, 2'b10, 0, 0); send(32'h40000004, 2'b01, 1, 0);
    send(32'h40000005, 2'b11, 0, 0); send(32'h40000006, 2'b11, 1, 0);
    send(32'h40000007, 2'b10, 0, 0); send(32'h40000008, 2'b01, 1, 0);
    check("t5_stb",  mul_stb, 1);
    check("t5_mode", mode, 2'b00);
    check("t5_mask", prod_mask, 4'hF);
    check("t5_ins",  mul_ins, {32'h40000008, 32'h40000007, 32'h40000006, 32'h40000005,
                               32'h40000004, 32'h40000003, 32'h40000002, 32'h40000001});
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
